// File: rtl/sa_host_seq.sv
`default_nettype none
// ----------------------------------------------------------------------------
// sa_host_seq : initiator for the successive-approximation handshake; issues one
// target at a time, captures the sa result and reports error/tolerance/timeout.
// Rev 1.0
// ----------------------------------------------------------------------------
module sa_host_seq #(
  parameter int Y_W       = 10,
  parameter int X_W       = 4,
  parameter int SETUP_CYC = 2,
  parameter int START_CYC = 1,
  parameter int TIMEOUT   = 64,
  parameter int TOL       = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           req_valid,
  output logic           req_ready,
  input  logic [Y_W-1:0] req_target,
  output logic [Y_W-1:0] sa_y_t,
  output logic           sa_start,
  input  logic [X_W-1:0] sa_x,
  input  logic [Y_W-1:0] sa_y,
  input  logic           sa_done,
  output logic           rsp_valid,
  input  logic           rsp_ready,
  output logic [X_W-1:0] rsp_x,
  output logic [Y_W-1:0] rsp_y,
  output logic [Y_W:0]   rsp_err,
  output logic           rsp_ok,
  output logic           rsp_timeout,
  output logic           busy
);

  localparam int CNT_MAX = TIMEOUT + SETUP_CYC + START_CYC;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic signed [Y_W:0] POS_TOL = (Y_W+1)'(TOL);
  localparam logic signed [Y_W:0] NEG_TOL = -POS_TOL;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SETUP = 3'd1,
    S_START = 3'd2,
    S_WAIT  = 3'd3,
    S_RESP  = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               done_q, done_d;
  logic [Y_W-1:0]     sa_y_t_q, sa_y_t_d;
  logic               sa_start_q, sa_start_d;
  logic               req_ready_q, req_ready_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic [X_W-1:0]     rsp_x_q, rsp_x_d;
  logic [Y_W-1:0]     rsp_y_q, rsp_y_d;
  logic [Y_W:0]       rsp_err_q, rsp_err_d;
  logic               rsp_ok_q, rsp_ok_d;
  logic               rsp_timeout_q, rsp_timeout_d;
  logic               busy_q, busy_d;

  logic               done_rise;
  logic [Y_W:0]       err_w;
  logic               ok_w;

  assign done_rise = sa_done & ~done_q;
  assign err_w     = {1'b0, sa_y} - {1'b0, sa_y_t_q};
  assign ok_w      = ($signed(err_w) >= NEG_TOL) && ($signed(err_w) <= POS_TOL);

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    done_d        = sa_done;
    sa_y_t_d      = sa_y_t_q;
    rsp_x_d       = rsp_x_q;
    rsp_y_d       = rsp_y_q;
    rsp_err_d     = rsp_err_q;
    rsp_ok_d      = rsp_ok_q;
    rsp_timeout_d = rsp_timeout_q;

    case (state_q)
      S_IDLE: begin
        if (req_valid && req_ready_q) begin
          sa_y_t_d = req_target;
          cnt_d    = '0;
          state_d  = S_SETUP;
        end
      end
      S_SETUP: begin
        // SETUP_CYC+1 periods here puts the sa_start rise SETUP_CYC+1 edges after accept
        if (cnt_q == CNT_W'(SETUP_CYC)) begin
          cnt_d   = '0;
          state_d = S_START;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_START: begin
        if (cnt_q == CNT_W'(START_CYC - 1)) begin
          cnt_d   = '0;
          state_d = S_WAIT;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_WAIT: begin
        // a done edge on the last timeout cycle still counts as a completion
        if (done_rise) begin
          rsp_x_d       = sa_x;
          rsp_y_d       = sa_y;
          rsp_err_d     = err_w;
          rsp_ok_d      = ok_w;
          rsp_timeout_d = 1'b0;
          state_d       = S_RESP;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          rsp_x_d       = '0;
          rsp_y_d       = '0;
          rsp_err_d     = '0;
          rsp_ok_d      = 1'b0;
          rsp_timeout_d = 1'b1;
          state_d       = S_RESP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_RESP: begin
        if (rsp_ready && rsp_valid_q) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // status outputs are registered decodes of the next state
    req_ready_d = (state_d == S_IDLE);
    busy_d      = (state_d != S_IDLE);
    sa_start_d  = (state_d == S_START);
    rsp_valid_d = (state_d == S_RESP);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      done_q        <= 1'b0;
      sa_y_t_q      <= '0;
      sa_start_q    <= 1'b0;
      req_ready_q   <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_x_q       <= '0;
      rsp_y_q       <= '0;
      rsp_err_q     <= '0;
      rsp_ok_q      <= 1'b0;
      rsp_timeout_q <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      done_q        <= done_d;
      sa_y_t_q      <= sa_y_t_d;
      sa_start_q    <= sa_start_d;
      req_ready_q   <= req_ready_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_x_q       <= rsp_x_d;
      rsp_y_q       <= rsp_y_d;
      rsp_err_q     <= rsp_err_d;
      rsp_ok_q      <= rsp_ok_d;
      rsp_timeout_q <= rsp_timeout_d;
      busy_q        <= busy_d;
    end
  end

  assign req_ready   = req_ready_q;
  assign sa_y_t      = sa_y_t_q;
  assign sa_start    = sa_start_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_x       = rsp_x_q;
  assign rsp_y       = rsp_y_q;
  assign rsp_err     = rsp_err_q;
  assign rsp_ok      = rsp_ok_q;
  assign rsp_timeout = rsp_timeout_q;
  assign busy        = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_sa_host_seq.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_sa_host_seq : directed vector bench for sa_host_seq with a simple sa core model.
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_sa_host_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [9:0]  req_target = '0;
  logic [9:0]  sa_y_t;
  logic        sa_start;
  logic [3:0]  sa_x = '0;
  logic [9:0]  sa_y = '0;
  logic        sa_done = 1'b0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [3:0]  rsp_x;
  logic [9:0]  rsp_y;
  logic [10:0] rsp_err;
  logic        rsp_ok;
  logic        rsp_timeout;
  logic        busy;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  sa_host_seq #(
    .Y_W(10), .X_W(4), .SETUP_CYC(2), .START_CYC(1), .TIMEOUT(64), .TOL(4)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_target(req_target),
    .sa_y_t(sa_y_t), .sa_start(sa_start),
    .sa_x(sa_x), .sa_y(sa_y), .sa_done(sa_done),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_x(rsp_x), .rsp_y(rsp_y), .rsp_err(rsp_err),
    .rsp_ok(rsp_ok), .rsp_timeout(rsp_timeout), .busy(busy)
  );

  typedef struct {
    logic [9:0]  tgt;
    logic [3:0]  x;
    logic [9:0]  y;
    int          dly;
    int          hold;
    logic [10:0] e_err;
    logic        e_ok;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_req_ready"},   req_ready,   0);
    chk({tag, "_sa_y_t"},      sa_y_t,      0);
    chk({tag, "_sa_start"},    sa_start,    0);
    chk({tag, "_rsp_valid"},   rsp_valid,   0);
    chk({tag, "_rsp_err"},     rsp_err,     0);
    chk({tag, "_rsp_timeout"}, rsp_timeout, 0);
    chk({tag, "_busy"},        busy,        0);
  endtask

  // Called at a negedge; returns at the negedge following the accept edge.
  task automatic do_req(input logic [9:0] t);
    int n = 0;
    req_target = t;
    req_valid  = 1'b1;
    while (req_ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("req_ready_wait", (req_ready === 1'b1), 1);
    @(negedge clk);
    req_valid = 1'b0;
    chk("sa_y_t_latch", sa_y_t, t);
    chk("req_ready_low", req_ready, 0);
  endtask

  // Returns at the negedge of the first WAIT cycle.
  task automatic wait_start();
    int lat = 0;
    int w = 0;
    while (sa_start !== 1'b1 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk("start_latency", lat, 3);
    while (sa_start === 1'b1 && w < 20) begin
      @(negedge clk);
      w++;
    end
    chk("start_width", w, 1);
  endtask

  task automatic wait_rsp(output int n);
    n = 0;
    while (rsp_valid !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic finish_rsp();
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    sa_done   = 1'b0;
    chk("rsp_valid_drop", rsp_valid, 0);
    chk("busy_after_rsp", busy, 0);
    chk("req_ready_after_rsp", req_ready, 1);
  endtask

  initial begin
    int n;
    bit bad;

    vecs[0] = '{tgt: 10'd630,  x: 4'd9,  y: 10'd632,  dly: 2, hold: 0, e_err: 11'h002, e_ok: 1'b1};
    vecs[1] = '{tgt: 10'd780,  x: 4'd3,  y: 10'd770,  dly: 1, hold: 5, e_err: 11'h7F6, e_ok: 1'b0};
    vecs[2] = '{tgt: 10'd100,  x: 4'd5,  y: 10'd104,  dly: 0, hold: 0, e_err: 11'h004, e_ok: 1'b1};
    vecs[3] = '{tgt: 10'd100,  x: 4'd4,  y: 10'd96,   dly: 3, hold: 0, e_err: 11'h7FC, e_ok: 1'b1};
    vecs[4] = '{tgt: 10'd100,  x: 4'd6,  y: 10'd105,  dly: 1, hold: 0, e_err: 11'h005, e_ok: 1'b0};
    vecs[5] = '{tgt: 10'd0,    x: 4'd15, y: 10'd1023, dly: 2, hold: 0, e_err: 11'h3FF, e_ok: 1'b0};
    vecs[6] = '{tgt: 10'd1023, x: 4'd0,  y: 10'd0,    dly: 0, hold: 0, e_err: 11'h401, e_ok: 1'b0};
    vecs[7] = '{tgt: 10'd500,  x: 4'd12, y: 10'd500,  dly: 4, hold: 0, e_err: 11'h000, e_ok: 1'b1};

    // power-up reset
    repeat (2) @(negedge clk);
    chk_idle_outputs("por");
    rst = 1'b0;
    @(negedge clk);
    chk("por_req_ready", req_ready, 1);

    // reset asserted mid-SETUP aborts silently
    do_req(10'd300);
    rst = 1'b1;
    #1;
    chk_idle_outputs("midrst");
    @(negedge clk);
    rst = 1'b0;
    bad = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (c == 5) sa_done = 1'b1;
      if (c == 8) sa_done = 1'b0;
      @(negedge clk);
      if (rsp_valid !== 1'b0 || sa_start !== 1'b0) bad = 1'b1;
    end
    chk("midrst_no_activity", bad, 0);
    chk("midrst_req_ready", req_ready, 1);
    chk("midrst_busy", busy, 0);

    // table vectors, issued back to back
    for (int i = 0; i < 8; i++) begin
      do_req(vecs[i].tgt);
      chk("busy_running", busy, 1);
      wait_start();
      repeat (vecs[i].dly) @(negedge clk);
      sa_x    = vecs[i].x;
      sa_y    = vecs[i].y;
      sa_done = 1'b1;
      wait_rsp(n);
      chk("done_to_rsp", n, 1);
      chk("rsp_x",       rsp_x,       vecs[i].x);
      chk("rsp_y",       rsp_y,       vecs[i].y);
      chk("rsp_err",     rsp_err,     vecs[i].e_err);
      chk("rsp_ok",      rsp_ok,      vecs[i].e_ok);
      chk("rsp_timeout", rsp_timeout, 0);
      sa_y = ~vecs[i].y;
      sa_x = ~vecs[i].x;
      for (int h = 0; h < vecs[i].hold; h++) begin
        @(negedge clk);
        chk("hold_valid",     rsp_valid, 1);
        chk("hold_err",       rsp_err,   vecs[i].e_err);
        chk("hold_y",         rsp_y,     vecs[i].y);
        chk("hold_req_ready", req_ready, 0);
      end
      finish_rsp();
    end

    // sa_done never rises: timeout after 64 WAIT cycles
    do_req(10'd200);
    wait_start();
    sa_x = 4'd5;
    sa_y = 10'd199;
    wait_rsp(n);
    chk("to_cycles",  n,           64);
    chk("to_flag",    rsp_timeout, 1);
    chk("to_ok",      rsp_ok,      0);
    chk("to_x",       rsp_x,       0);
    chk("to_y",       rsp_y,       0);
    chk("to_err",     rsp_err,     0);
    finish_rsp();

    // done edge on the final timeout cycle wins
    do_req(10'd200);
    wait_start();
    repeat (63) @(negedge clk);
    sa_x    = 4'd7;
    sa_y    = 10'd203;
    sa_done = 1'b1;
    wait_rsp(n);
    chk("last_done_to_rsp", n,           1);
    chk("last_timeout",     rsp_timeout, 0);
    chk("last_y",           rsp_y,       203);
    chk("last_err",         rsp_err,     11'h003);
    chk("last_ok",          rsp_ok,      1);
    finish_rsp();

    // sa_done already high at WAIT entry: only a fresh rise captures
    sa_done = 1'b1;
    sa_x    = 4'd1;
    sa_y    = 10'd1;
    do_req(10'd630);
    wait_start();
    bad = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (rsp_valid !== 1'b0) bad = 1'b1;
    end
    chk("stuck_no_capture", bad, 0);
    sa_done = 1'b0;
    @(negedge clk);
    sa_x    = 4'd9;
    sa_y    = 10'd632;
    sa_done = 1'b1;
    wait_rsp(n);
    chk("stuck_done_to_rsp", n,       1);
    chk("stuck_x",           rsp_x,   9);
    chk("stuck_y",           rsp_y,   632);
    chk("stuck_err",         rsp_err, 11'h002);
    chk("stuck_ok",          rsp_ok,  1);
    finish_rsp();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
